// File: rtl/booth_mult_r4_hs.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
// Signed/unsigned per operation, one radix-4 step per cycle, one multiply in flight.
module booth_mult_r4_hs #(
  parameter int A_WIDTH = 24,
  parameter int B_WIDTH = 8,
  parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] P,
  output logic               busy
);

  localparam int ACC_W = A_WIDTH + B_WIDTH + 2;
  localparam int BX_W  = B_WIDTH + 2;
  localparam int CNT_W = $clog2(B_WIDTH / 2 + 2);

  if (A_WIDTH < 2) begin : g_chk_a
    $error("booth_mult_r4_hs: A_WIDTH must be >= 2");
  end
  if ((B_WIDTH % 2) != 0 || B_WIDTH < 2) begin : g_chk_b
    $error("booth_mult_r4_hs: B_WIDTH must be even and >= 2");
  end
  if (P_WIDTH != A_WIDTH + B_WIDTH) begin : g_chk_p
    $error("booth_mult_r4_hs: P_WIDTH must equal A_WIDTH + B_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   m_q, m_d;       // extended multiplicand, pre-shifted to weight 4^i
  logic [BX_W-1:0]    b_q, b_d;       // extended multiplier, consumed two bits per step
  logic               prev_q, prev_d; // B[2i-1] for the current triplet
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_WIDTH-1:0] p_q, p_d;
  logic [ACC_W-1:0]   booth_add;

  always_comb begin
    booth_add = '0;
    unique case ({b_q[1], b_q[0], prev_q})
      3'b001, 3'b010: booth_add = m_q;
      3'b011:         booth_add = m_q << 1;
      3'b100:         booth_add = -(m_q << 1);
      3'b101, 3'b110: booth_add = -m_q;
      default:        booth_add = '0;
    endcase
  end

  // NOTE: every next-state signal is defaulted to its register first so no
  // path through the case below can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    b_d     = b_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {{(ACC_W - A_WIDTH){signed_mode & A[A_WIDTH-1]}}, A};
          b_d     = {{2{signed_mode & B[B_WIDTH-1]}}, B};
          prev_d  = 1'b0;
          acc_d   = '0;
          // Unsigned needs one extra step to consume the zero-extension bits.
          cnt_d   = signed_mode ? CNT_W'(B_WIDTH / 2) : CNT_W'(B_WIDTH / 2 + 1);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_q + booth_add;
        m_d    = m_q << 2;
        b_d    = {{2{b_q[BX_W-1]}}, b_q[BX_W-1:2]};
        prev_d = b_q[1];
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          p_d     = acc_d[P_WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      b_q     <= '0;
      prev_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      b_q     <= b_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = p_q;

endmodule

// File: tb/tb_booth_mult_r4_hs.sv
// Directed-vector and randomized bench for booth_mult_r4_hs (default widths 24x8).
module tb_booth_mult_r4_hs;

  localparam int AW = 24;
  localparam int BW = 8;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] A = '0;
  logic [BW-1:0] B = '0;
  logic          signed_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] P;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;

  booth_mult_r4_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .P(P), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid && out_ready) hs_count++;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          m;
    logic [PW-1:0] exp;
    int            stall;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                          input logic m);
    longint x, y;
    if (m) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return PW'(x * y);
  endfunction

  // One full transaction: accept, count latency, hold under back-pressure, release.
  task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic m,
                        input logic [PW-1:0] exp, input int stall, input string name);
    int  k;
    bit  ok;
    @(negedge clk);
    A = a; B = b; signed_mode = m; in_valid = 1'b1;
    check({name, " in_ready_before"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = AW'($urandom); B = BW'($urandom); signed_mode = ~m;
    k = 0;
    ok = 1'b1;
    while (1) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_valid || k > 20) break;
      if (in_ready || !busy) ok = 1'b0;
    end
    check({name, " latency"}, 64'(k), m ? 64'd4 : 64'd5);
    check({name, " P"}, 64'(P), 64'(exp));
    check({name, " calc_flags"}, 64'(ok && busy && !in_ready), 64'd1);
    if (stall > 0) begin
      ok = 1'b1;
      in_valid = 1'b1;
      repeat (stall) begin
        A = AW'($urandom); B = BW'($urandom);
        @(negedge clk);
        if (P !== exp || !out_valid || in_ready || !busy) ok = 1'b0;
      end
      in_valid = 1'b0;
      check({name, " stall_stable"}, 64'(ok), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, " after_hs"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    check({name, " P_hold"}, 64'(P), 64'(exp));
  endtask

  initial begin
    vec_t vecs[12];
    int   hs_start;
    vecs[0]  = '{24'h00000F, 8'h09, 1'b1, 32'h00000087, 0};
    vecs[1]  = '{24'h800000, 8'h80, 1'b1, 32'h40000000, 0};
    vecs[2]  = '{24'h800000, 8'h7F, 1'b1, 32'hC0800000, 2};
    vecs[3]  = '{24'hFFFFFF, 8'hFF, 1'b0, 32'hFEFFFF01, 0};
    vecs[4]  = '{24'hFFFFFF, 8'hFF, 1'b1, 32'h00000001, 0};
    vecs[5]  = '{24'h000000, 8'h5B, 1'b1, 32'h00000000, 0};
    vecs[6]  = '{24'h7FFFFF, 8'h7F, 1'b1, 32'h3F7FFF81, 0};
    vecs[7]  = '{24'h000064, 8'h80, 1'b0, 32'h00003200, 1};
    vecs[8]  = '{24'h123456, 8'h00, 1'b0, 32'h00000000, 0};
    vecs[9]  = '{24'hFFFFFF, 8'h02, 1'b1, 32'hFFFFFFFE, 0};
    vecs[10] = '{24'h000010, 8'h80, 1'b1, 32'hFFFFF800, 0};
    vecs[11] = '{24'h000003, 8'hFE, 1'b1, 32'hFFFFFFFA, 0};

    #12;
    check("reset_state", {28'd0, P[3:0] | {3'd0, |P}, out_valid, in_ready, busy}, 64'b010);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));

    // Back-pressure for 10 cycles with new operands offered, then accept right after.
    run_op(24'h00000F, 8'h09, 1'b1, 32'h00000087, 10, "bp");
    run_op(24'h000005, 8'h07, 1'b0, 32'h00000023, 0, "bp_next");

    // Asynchronous reset two cycles into CALC.
    @(negedge clk);
    A = 24'h000123; B = 8'h45; signed_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("rst_mid_P", 64'(P), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(24'h000003, 8'hFE, 1'b1, 32'hFFFFFFFA, 0, "post_rst");

    // Random regression with stalls and operands toggled during CALC.
    hs_start = hs_count;
    for (int i = 0; i < 1000; i++) begin
      logic [AW-1:0] ra;
      logic [BW-1:0] rb;
      logic          rm;
      ra = AW'($urandom);
      rb = BW'($urandom);
      rm = 1'($urandom);
      if (i % 50 == 0) ra = {1'b1, {(AW-1){1'b0}}};
      run_op(ra, rb, rm, model(ra, rb, rm), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end
    check("rnd_handshakes", 64'(hs_count - hs_start), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mult_r4_hs.md
Name: booth_mult_r4_hs

Overview:
- Parametrised, iterative radix-4 Booth multiplier. Successor to the load-pulse booth_mult.
- Adds valid/ready handshakes on both input and output.
- Adds per-operation signed/unsigned mode, a busy flag and output back-pressure.
- Sits between an upstream operand producer and a downstream consumer in the datapath. One multiply in flight at a time.

Parameters:
- A_WIDTH, 24, multiplicand width; must be >= 2.
- B_WIDTH, 8, multiplier width; must be even and >= 2. An odd value raises an elaboration-time $error.
- P_WIDTH, A_WIDTH+B_WIDTH, product width. Any other value raises an elaboration-time $error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands.
- A  input  A_WIDTH  multiplicand.
- B  input  B_WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  P holds a completed product.
- out_ready  input  1  downstream accepts P.
- P  output  P_WIDTH  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, P=0, all internal registers 0. Reset takes effect immediately, including mid-CALC or mid-DONE. Any in-flight operation is discarded with no output.
- Reset deassertion: the first accept is possible on the first rising edge with rst_n=1.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture A, B and signed_mode into internal registers. Clear the accumulator, load the iteration counter, go to CALC. Later input changes have no effect.
  - CALC: in_ready=0. One radix-4 Booth step per cycle.
    - Examine the triplet {B[2i+1], B[2i], B[2i-1]} with B[-1]=0.
    - Add 0, ±A_ext or ±2*A_ext to the accumulator at weight 4^i.
    - A_ext = A extended by 2 bits: sign-extended if signed_mode=1, zero-extended if 0.
    - B is extended the same way.
  - Iteration count N: B_WIDTH/2 when signed_mode=1; B_WIDTH/2+1 when signed_mode=0 (the extra step uses the zero-extension bits). After the final step, go to DONE.
  - DONE: out_valid=1, P = accumulator truncated to P_WIDTH.
    - On out_ready=1, go to IDLE next edge.
    - While out_ready=0, hold P and out_valid stable indefinitely.
- Latency: acceptance at edge 0 gives out_valid=1 after edge N. The signed default is 4 cycles; unsigned is 5.
- Throughput: one result per N+2 cycles with out_ready tied high.
- P register:
  - Updates only on entry to DONE.
  - Holds its last value after the output handshake, until the next result or reset.
  - Must not show intermediate accumulator values.
- Arithmetic:
  - Internal accumulator width is A_WIDTH+B_WIDTH+2, so no overflow occurs.
  - The result must equal $signed(A)*$signed(B) in signed mode and A*B in unsigned mode, modulo 2^P_WIDTH.
  - Edge cases are exact: most-negative × most-negative, zero operands, and all-ones unsigned.
- busy = (state != IDLE). in_ready = (state == IDLE). in_valid is ignored when in_ready=0.

Test Plan:
- Reset then signed_mode=1, A=15, B=9 accepted → out_valid=1 exactly 4 cycles after accept, P=135. in_ready=0 and busy=1 throughout CALC/DONE.
- signed_mode=1, A=24'h800000, B=8'h80 → P=32'h40000000. Then A=24'h800000, B=8'h7F → P=32'hC0800000.
- signed_mode=0, A=24'hFFFFFF, B=8'hFF → out_valid after 5 cycles, P=32'hFEFFFF01. The same operands with signed_mode=1 → P=32'h00000001.
- Back-pressure: out_ready=0 for 10 cycles after out_valid → P and out_valid stable, in_ready=0, new in_valid ignored. out_ready=1 → IDLE next cycle, then accept succeeds.
- Reset mid-operation: assert rst_n=0 two cycles into CALC → out_valid=0, P=0, in_ready=1 immediately (asynchronous). The next operation A=3, B=-2 (8'hFE) signed → P=32'hFFFFFFFA.
- Random regression: 1000 operations, random A/B/signed_mode, random out_ready stalls, A/B toggled during CALC → every P matches the reference model and each operation produces exactly one output handshake.
